// File: rtl/seq_signed_divider.sv
// seq_signed_divider: iterative radix-2 restoring signed divider behind an
// AXI-Stream operand pair. One restoring step per cycle over WIDTH cycles,
// then a sign-fixup cycle, then the result waits on the output stream.
//
// Optional build macro: DIV_ZERO_FLAG_EN adds m_axis_dout_tuser, a
// divide-by-zero flag that travels with the result.
//
// state | meaning
// IDLE  | both operand streams ready; waits for both tvalid together
// BUSY  | WIDTH shift/subtract steps (count WIDTH-1..0), then sign fixup
// DONE  | result presented on m_axis_dout, held until accepted downstream
module seq_signed_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  output logic               m_axis_dout_tvalid,
  input  logic               m_axis_dout_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic               m_axis_dout_tuser
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               step_done;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_mag;
  logic [WIDTH-1:0]   dvd_raw;
  logic               dvd_neg;
  logic               q_neg;
  logic               div_zero;
  logic               dout_valid;
  logic [2*WIDTH-1:0] dout_data;
`ifdef DIV_ZERO_FLAG_EN
  logic               dout_user;
`endif

  logic               accept;
  logic [WIDTH-1:0]   dvd_abs;
  logic [WIDTH-1:0]   dvs_abs;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic               step_bit;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  // Ready is gated by reset directly so it reads 0 while rst_in is high and
  // 1 as soon as reset releases, without waiting for a clock edge.
  assign s_axis_dividend_tready = (state == IDLE) && !rst_in;
  assign s_axis_divisor_tready  = (state == IDLE) && !rst_in;
  assign accept = (state == IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;

  assign m_axis_dout_tvalid = dout_valid;
  assign m_axis_dout_tdata  = dout_data;
`ifdef DIV_ZERO_FLAG_EN
  assign m_axis_dout_tuser  = dout_user;
`endif

  // Magnitudes of the incoming operands; -2^(W-1) maps to 2^(W-1) unsigned.
  always_comb begin
    dvd_abs = s_axis_dividend_tdata;
    dvs_abs = s_axis_divisor_tdata;
    if (s_axis_dividend_tdata[WIDTH-1]) dvd_abs = -s_axis_dividend_tdata;
    if (s_axis_divisor_tdata[WIDTH-1])  dvs_abs = -s_axis_divisor_tdata;
  end

  // One restoring step: shift in the next dividend bit, try to subtract.
  // The partial remainder is WIDTH+1 bits so the borrow shows in the top bit.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvs_mag};
    step_bit = ~trial[WIDTH];
    step_rem = shifted[WIDTH-1:0];
    if (step_bit) step_rem = trial[WIDTH-1:0];
  end

  // Sign fixup: quotient negative when signs differ, remainder follows dividend.
  always_comb begin
    q_fix = quo_q;
    r_fix = rem_q;
    if (q_neg)   q_fix = -quo_q;
    if (dvd_neg) r_fix = -rem_q;
  end

  // Control FSM and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      count      <= '0;
      step_done  <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_mag    <= '0;
      dvd_raw    <= '0;
      dvd_neg    <= 1'b0;
      q_neg      <= 1'b0;
      div_zero   <= 1'b0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
`ifdef DIV_ZERO_FLAG_EN
      dout_user  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvd_raw   <= s_axis_dividend_tdata;
            dvd_neg   <= s_axis_dividend_tdata[WIDTH-1];
            q_neg     <= s_axis_dividend_tdata[WIDTH-1] ^ s_axis_divisor_tdata[WIDTH-1];
            div_zero  <= (s_axis_divisor_tdata == '0);
            dvs_mag   <= dvs_abs;
            quo_q     <= dvd_abs;
            rem_q     <= '0;
            count     <= CW'(WIDTH - 1);
            step_done <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (!step_done) begin
            rem_q <= step_rem;
            quo_q <= {quo_q[WIDTH-2:0], step_bit};
            if (count == '0) step_done <= 1'b1;
            else             count     <= count - CW'(1);
          end else begin
            // Divide-by-zero bypasses the iterated result so the remainder is
            // the original signed dividend; latency is unchanged.
            if (div_zero) dout_data <= {{WIDTH{1'b1}}, dvd_raw};
            else          dout_data <= {q_fix, r_fix};
`ifdef DIV_ZERO_FLAG_EN
            dout_user  <= div_zero;
`endif
            dout_valid <= 1'b1;
            step_done  <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          if (m_axis_dout_tready) begin
            dout_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider (WIDTH = 32): vector table with
// hand-computed quotient/remainder plus backpressure and mid-BUSY reset cases.
module tb_seq_signed_divider;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dvd_valid = 1'b0;
  logic          dvd_ready;
  logic [W-1:0]  dvd_data = '0;
  logic          dvs_valid = 1'b0;
  logic          dvs_ready;
  logic [W-1:0]  dvs_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] out_data;
`ifdef DIV_ZERO_FLAG_EN
  logic          out_user;
`endif

  int checks = 0;
  int failures = 0;

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk_in                 (clk),
    .rst_in                 (rst),
    .s_axis_dividend_tvalid (dvd_valid),
    .s_axis_dividend_tready (dvd_ready),
    .s_axis_dividend_tdata  (dvd_data),
    .s_axis_divisor_tvalid  (dvs_valid),
    .s_axis_divisor_tready  (dvs_ready),
    .s_axis_divisor_tdata   (dvs_data),
    .m_axis_dout_tvalid     (out_valid),
    .m_axis_dout_tready     (out_ready),
    .m_axis_dout_tdata      (out_data)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .m_axis_dout_tuser      (out_user)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         zf;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Count edges after the acceptance edge until tvalid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 100);
  endtask

  // Present a pair (caller is #1 after an edge), accept on the next edge,
  // scramble the inputs, then wait for the result.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    dvd_data  = a;
    dvs_data  = b;
    dvd_valid = 1'b1;
    dvs_valid = 1'b1;
    chk("dividend_tready_idle", dvd_ready, 1);
    chk("divisor_tready_idle", dvs_ready, 1);
    @(posedge clk);
    #1;
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    dvd_data  = $urandom;
    dvs_data  = $urandom;
    chk("tready_busy", {dvd_ready, dvs_ready}, 0);
    wait_valid(lat);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("tvalid_after_handshake", out_valid, 0);
  endtask

  initial begin
    int lat;
    bit seen;

    vecs[0]  = '{32'd9,        32'd3,        32'd3,        32'd0,        1'b0};
    vecs[1]  = '{32'd100,      32'd5,        32'd20,       32'd0,        1'b0};
    vecs[2]  = '{32'h0000FFFF, 32'd9,        32'd7281,     32'd6,        1'b0};
    vecs[3]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
    vecs[5]  = '{32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1};
    vecs[6]  = '{32'd9,        32'd3,        32'd3,        32'd0,        1'b0};
    vecs[7]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
    vecs[8]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    vecs[9]  = '{32'hFFFFFFF7, 32'hFFFFFFFD, 32'd3,        32'd0,        1'b0};
    vecs[10] = '{32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dividend_tready", dvd_ready, 0);
    chk("rst_divisor_tready", dvs_ready, 0);
    chk("rst_tvalid", out_valid, 0);
    chk("rst_tdata", out_data, 0);
`ifdef DIV_ZERO_FLAG_EN
    chk("rst_tuser", out_user, 0);
`endif
    rst = 1'b0;
    #1;
    chk("tready_after_release", {dvd_ready, dvs_ready}, 2'b11);
    @(posedge clk);
    #1;

    // Back-to-back vectors with downstream always ready
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].dvd, vecs[i].dvs, lat);
      chk($sformatf("latency[%0d]", i), lat, LAT);
      chk($sformatf("quotient[%0d]", i), out_data[2*W-1:W], vecs[i].q);
      chk($sformatf("remainder[%0d]", i), out_data[W-1:0], vecs[i].r);
`ifdef DIV_ZERO_FLAG_EN
      chk($sformatf("tuser[%0d]", i), out_user, vecs[i].zf);
`endif
      handshake();
    end

    // Only one operand valid: nothing accepted, no result appears
    dvd_data = 32'd40;
    dvs_data = 32'd4;
    dvd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    dvd_valid = 1'b0;
    dvs_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    dvs_valid = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    chk("single_valid_no_result", seen, 0);
    chk("single_valid_still_ready", dvd_ready, 1);

    // Output backpressure while new operands are offered
    out_ready = 1'b0;
    do_op(32'd81, 32'd9, lat);
    chk("bp_latency", lat, LAT);
    chk("bp_result", out_data, {32'd9, 32'd0});
    dvd_data  = 32'd50;
    dvs_data  = 32'd5;
    dvd_valid = 1'b1;
    dvs_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      chk("bp_tdata_held", out_data, {32'd9, 32'd0});
      chk("bp_tvalid_held", out_valid, 1);
      chk("bp_input_tready", {dvd_ready, dvs_ready}, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_tvalid_after_handshake", out_valid, 0);
    chk("bp_tready_after_handshake", {dvd_ready, dvs_ready}, 2'b11);
    @(posedge clk);
    #1;
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    chk("bp_next_accepted", {dvd_ready, dvs_ready}, 0);
    wait_valid(lat);
    chk("bp_next_latency", lat, LAT);
    chk("bp_next_result", out_data, {32'd10, 32'd0});
    handshake();

    // Asynchronous reset 10 cycles into BUSY
    dvd_data  = 32'd1000;
    dvs_data  = 32'd3;
    dvd_valid = 1'b1;
    dvs_valid = 1'b1;
    @(posedge clk);
    #1;
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #2;
    chk("midbusy_rst_tready", {dvd_ready, dvs_ready}, 0);
    chk("midbusy_rst_tvalid", out_valid, 0);
    #10;
    rst = 1'b0;
    #1;
    chk("midbusy_release_tready", {dvd_ready, dvs_ready}, 2'b11);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    chk("midbusy_no_result", seen, 0);
    do_op(32'd100, 32'd5, lat);
    chk("post_reset_latency", lat, LAT);
    chk("post_reset_result", out_data, {32'd20, 32'd0});
`ifdef DIV_ZERO_FLAG_EN
    chk("post_reset_tuser", out_user, 0);
`endif
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
